hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/control_pkg.sv | 79 +++++++
 rtl/hazard_unit_if.sv | 58 +++++
 rtl/hazard_unit_sat_counter.sv | 38 +++
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
//   Shared control-path types for the pipeline: operand/PC select enums, the
//   hazard unit FSM state, the packed bundle of pipeline-register controls the
//   hazard unit drives, and the register-match helper used for hazard checks.
// -----------------------------------------------------------------------------
package control_pkg;

    // Operand forwarding source select.
    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } fwd_sel_e;

    // Next-PC source select.
    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JALR   = 2'd2
    } pc_sel_e;

    // Hazard unit FSM: RUN normally, MEMWAIT while a data access is outstanding.
    typedef enum logic {
        HZ_RUN     = 1'b0,
        HZ_MEMWAIT = 1'b1
    } hz_state_e;

    // Pipeline register controls, MSB first: four enables, two flushes, bubble.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_OFF = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
    };

    localparam hz_ctrl_t HZ_CTRL_NORMAL = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
    };

    // Hold PC and IF/ID, inject a NOP into ID/EX, let older stages drain.
    localparam hz_ctrl_t HZ_CTRL_DATA_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
    };

    localparam hz_ctrl_t HZ_CTRL_REDIRECT = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
    };

    // Freeze everything up to MEM; WB gets a bubble so it does not retire twice.
    localparam hz_ctrl_t HZ_CTRL_MEM_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b1
    };

    // True when destination rd is a live source of the ID instruction.
    // x0 is hardwired to zero and never creates a dependency.
    function automatic logic src_match(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2
    );
        return (rd != 5'd0) && ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
//   Pipeline <-> hazard unit signal bundle.
//   Pipeline-sourced: ID sources/uses, branch info, EX/MEM destinations and
//   load flags, data memory request/ready.
//   Hazard-unit-sourced: register enables, flushes, MEM/WB bubble, FSM state,
//   saturating stall counter, sticky memory timeout flag.
//   master = pipeline side, slave = hazard unit.
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]              if_id_rs1;
    logic [4:0]              if_id_rs2;
    logic                    if_id_use_rs1;
    logic                    if_id_use_rs2;
    logic                    if_id_is_branch;
    logic                    branch_taken;
    logic [4:0]              id_ex_rd;
    logic                    id_ex_reg_write;
    logic                    id_ex_mem_read;
    logic [4:0]              ex_mem_rd;
    logic                    ex_mem_mem_read;
    logic                    dmem_req;
    logic                    dmem_ready;

    logic                    pc_en;
    logic                    if_id_en;
    logic                    id_ex_en;
    logic                    ex_mem_en;
    logic                    if_id_flush;
    logic                    id_ex_flush;
    logic                    mem_wb_bubble;
    control_pkg::hz_state_e  hz_state;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    mem_timeout_err;

    modport master (
        output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
               if_id_is_branch, branch_taken,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read,
               ex_mem_rd, ex_mem_mem_read, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_bubble,
               hz_state, stall_cnt, mem_timeout_err
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
               if_id_is_branch, branch_taken,
               id_ex_rd, id_ex_reg_write, id_ex_mem_read,
               ex_mem_rd, ex_mem_mem_read, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_bubble,
               hz_state, stall_cnt, mem_timeout_err
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// hz_sat_counter
//   Saturating up-counter with synchronous clear (clear wins over inc).
//   Ports: clk, rst_n (async active-low), clear, inc -> cnt (WIDTH bits).
// -----------------------------------------------------------------------------
module hz_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard detection and stall/flush control.
//   Ports: clk, rst_n (async active-low), hz (hazard_unit_if.slave) carrying
//   ID/EX/MEM hazard inputs, data memory handshake, and the enables, flushes,
//   MEM/WB bubble, FSM state, stall counter and timeout flag outputs.
//   Pipeline controls are combinational so a memory stall freezes the
//   pipeline in the very cycle the access first fails to complete.
// -----------------------------------------------------------------------------
module hazard_unit
    import control_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);

    localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic              err_q;
    logic              err_d;

    logic              load_use;
    logic              br_hz;
    logic              mem_stall;
    logic              data_stall;
    logic              wait_clr;
    logic              wait_inc;
    logic              stall_inc;
    logic [CNT_W-1:0]  stall_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    hz_ctrl_t          ctrl;

    // Hazard detection.
    always_comb begin
        load_use = hz.id_ex_mem_read &&
                   src_match(hz.id_ex_rd, hz.if_id_rs1, hz.if_id_rs2,
                             hz.if_id_use_rs1, hz.if_id_use_rs2);

        // Branches resolve in ID, so any in-flight producer (ALU result still
        // in EX, or load still in MEM) must complete before comparing.
        br_hz = hz.if_id_is_branch &&
                ((hz.id_ex_reg_write &&
                  src_match(hz.id_ex_rd, hz.if_id_rs1, hz.if_id_rs2,
                            hz.if_id_use_rs1, hz.if_id_use_rs2)) ||
                 (hz.ex_mem_mem_read &&
                  src_match(hz.ex_mem_rd, hz.if_id_rs1, hz.if_id_rs2,
                            hz.if_id_use_rs1, hz.if_id_use_rs2)));

        mem_stall  = !hz.dmem_ready &&
                     (((state_q == HZ_RUN) && hz.dmem_req) || (state_q == HZ_MEMWAIT));
        data_stall = !mem_stall && (load_use || br_hz);
        stall_inc  = mem_stall || data_stall;
    end

    // Next state, wait counter control, sticky timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN:     if (hz.dmem_req && !hz.dmem_ready) state_d = HZ_MEMWAIT;
            HZ_MEMWAIT: if (hz.dmem_ready)                 state_d = HZ_RUN;
            default:    state_d = HZ_RUN;
        endcase

        wait_clr = (state_q == HZ_RUN) && (state_d == HZ_MEMWAIT);
        wait_inc = (state_q == HZ_MEMWAIT);

        // Flag rises on the same edge that takes wait_cnt to MEM_TIMEOUT.
        err_d = err_q || (wait_inc && (wait_cnt >= WAIT_LAST));
    end

    // Pipeline controls; reset overrides everything, then fixed priority.
    // A pending redirect is simply dropped while any stall is active: the
    // branch is re-evaluated once its operands or the memory become ready.
    always_comb begin
        ctrl = HZ_CTRL_NORMAL;
        if (!rst_n) begin
            ctrl = HZ_CTRL_OFF;
        end else if (mem_stall) begin
            ctrl = HZ_CTRL_MEM_STALL;
        end else if (data_stall) begin
            ctrl = HZ_CTRL_DATA_STALL;
        end else if (hz.branch_taken) begin
            ctrl = HZ_CTRL_REDIRECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    hz_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    hz_sat_counter #(
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wait_clr),
        .inc   (wait_inc),
        .cnt   (wait_cnt)
    );

    assign hz.pc_en           = ctrl.pc_en;
    assign hz.if_id_en        = ctrl.if_id_en;
    assign hz.id_ex_en        = ctrl.id_ex_en;
    assign hz.ex_mem_en       = ctrl.ex_mem_en;
    assign hz.if_id_flush     = ctrl.if_id_flush;
    assign hz.id_ex_flush     = ctrl.id_ex_flush;
    assign hz.mem_wb_bubble   = ctrl.mem_wb_bubble;
    assign hz.hz_state        = state_q;
    assign hz.stall_cnt       = stall_cnt;
    assign hz.mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Scenario bench for hazard_unit with a 3-bit stall counter (so saturation
//   is reachable) and MEM_TIMEOUT=4. Each scenario queues per-cycle stimulus
//   with the required controls; expected output vectors go through a
//   scoreboard queue and are compared mid-cycle.
//   Vector layout: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
//                   id_ex_flush, mem_wb_bubble, hz_state, stall_cnt[2:0], err}
// -----------------------------------------------------------------------------
module tb_hazard_unit;
    import control_pkg::*;

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 4;

    localparam logic [6:0] NORM   = 7'b1111_000;
    localparam logic [6:0] DSTALL = 7'b0011_010;
    localparam logic [6:0] REDIR  = 7'b1111_100;
    localparam logic [6:0] MSTALL = 7'b0000_001;
    localparam logic [6:0] OFF    = 7'b0000_000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       is_br;
        logic       taken;
        logic [4:0] exr;
        logic       exw;
        logic       exm;
        logic [4:0] mr;
        logic       mm;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic       rst;
        logic [6:0] ctrl;
        hz_state_e  st;
        logic       err;
    } step_t;

    typedef struct {
        string       name;
        logic [11:0] v;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    int               n_run  = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] exp_cnt;
    step_t            plan[$];
    exp_t             sb[$];

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_unit #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [11:0] observed();
        return {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
                hif.if_id_flush, hif.id_ex_flush, hif.mem_wb_bubble,
                hif.hz_state, hif.stall_cnt, hif.mem_timeout_err};
    endfunction

    task automatic drive(input stim_t s);
        hif.if_id_rs1       = s.rs1;
        hif.if_id_rs2       = s.rs2;
        hif.if_id_use_rs1   = s.use1;
        hif.if_id_use_rs2   = s.use2;
        hif.if_id_is_branch = s.is_br;
        hif.branch_taken    = s.taken;
        hif.id_ex_rd        = s.exr;
        hif.id_ex_reg_write = s.exw;
        hif.id_ex_mem_read  = s.exm;
        hif.ex_mem_rd       = s.mr;
        hif.ex_mem_mem_read = s.mm;
        hif.dmem_req        = s.req;
        hif.dmem_ready      = s.rdy;
    endtask

    task automatic add(input string name, input stim_t s, input logic rst,
                       input logic [6:0] ctrl, input hz_state_e st, input logic err);
        step_t p;
        p.name = name; p.s = s; p.rst = rst; p.ctrl = ctrl; p.st = st; p.err = err;
        plan.push_back(p);
    endtask

    task automatic test_reset();
        stim_t s;
        step_t p;
        exp_t  e;
        s = idle(); s.rs1 = 5; s.use1 = 1; s.exr = 5; s.exm = 1;
        s.taken = 1; s.req = 1;
        add("rst_hold_a", s, 1'b0, OFF, HZ_RUN, 1'b0);
        add("rst_hold_b", s, 1'b0, OFF, HZ_RUN, 1'b0);
        add("rst_release", idle(), 1'b1, NORM, HZ_RUN, 1'b0);
        while (plan.size() != 0) begin
            p = plan.pop_front();
            drive(p.s);
            rst_n = p.rst;
            if (!p.rst) exp_cnt = '0;
            e.name = p.name; e.v = {p.ctrl, p.st, exp_cnt, p.err};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.v);
            end
            if (p.rst && !p.ctrl[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        step_t p;
        exp_t  e;
        s = idle(); s.rs1 = 5; s.use1 = 1; s.exr = 5; s.exm = 1;
        add("lu_rs1_stall", s, 1'b1, DSTALL, HZ_RUN, 1'b0);
        add("lu_rs1_after", idle(), 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.rs2 = 9; s.use2 = 1; s.exr = 9; s.exm = 1; s.rs1 = 4; s.use1 = 1;
        add("lu_rs2_stall", s, 1'b1, DSTALL, HZ_RUN, 1'b0);
        s.use2 = 0;
        add("lu_rs2_unused", s, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.rs1 = 6; s.use1 = 1; s.exr = 6; s.exw = 1;
        add("alu_dep_fwd", s, 1'b1, NORM, HZ_RUN, 1'b0);
        while (plan.size() != 0) begin
            p = plan.pop_front();
            drive(p.s);
            rst_n = p.rst;
            if (!p.rst) exp_cnt = '0;
            e.name = p.name; e.v = {p.ctrl, p.st, exp_cnt, p.err};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.v);
            end
            if (p.rst && !p.ctrl[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t s;
        step_t p;
        exp_t  e;
        s = idle(); s.is_br = 1; s.rs2 = 7; s.use2 = 1; s.exr = 7; s.exw = 1;
        add("br_ex_dep", s, 1'b1, DSTALL, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.rs2 = 7; s.use2 = 1; s.mr = 7; s.mm = 1;
        add("br_mem_load", s, 1'b1, DSTALL, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.rs2 = 7; s.use2 = 1; s.taken = 1;
        add("br_taken", s, 1'b1, REDIR, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.rs2 = 7; s.use2 = 1; s.mr = 7;
        add("br_mem_alu", s, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.rs2 = 7; s.exr = 7; s.exw = 1;
        add("br_rs2_unused", s, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.taken = 1;
        add("jump_redirect", s, 1'b1, REDIR, HZ_RUN, 1'b0);
        while (plan.size() != 0) begin
            p = plan.pop_front();
            drive(p.s);
            rst_n = p.rst;
            if (!p.rst) exp_cnt = '0;
            e.name = p.name; e.v = {p.ctrl, p.st, exp_cnt, p.err};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.v);
            end
            if (p.rst && !p.ctrl[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_stall();
        stim_t s;
        stim_t w;
        step_t p;
        exp_t  e;
        add("ms_reset", idle(), 1'b0, OFF, HZ_RUN, 1'b0);
        w = idle(); w.req = 1;
        add("ms_first", w, 1'b1, MSTALL, HZ_RUN, 1'b0);
        add("ms_wait2", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        add("ms_wait3", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        w.rdy = 1;
        add("ms_ready", w, 1'b1, NORM, HZ_MEMWAIT, 1'b0);
        add("ms_back_run", idle(), 1'b1, NORM, HZ_RUN, 1'b0);
        add("ms_req_hit", w, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.rs1 = 8; s.use1 = 1; s.exr = 8; s.exm = 1; s.req = 1; s.taken = 1;
        add("ms_over_lu", s, 1'b1, MSTALL, HZ_RUN, 1'b0);
        add("ms_over_lu_w", s, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        s.rdy = 1;
        add("ms_rdy_lu", s, 1'b1, DSTALL, HZ_MEMWAIT, 1'b0);
        s = idle(); s.taken = 1; s.req = 1;
        add("ms_taken_drop", s, 1'b1, MSTALL, HZ_RUN, 1'b0);
        s.rdy = 1;
        add("ms_rdy_redir", s, 1'b1, REDIR, HZ_MEMWAIT, 1'b0);
        add("ms_tail", idle(), 1'b1, NORM, HZ_RUN, 1'b0);
        while (plan.size() != 0) begin
            p = plan.pop_front();
            drive(p.s);
            rst_n = p.rst;
            if (!p.rst) exp_cnt = '0;
            e.name = p.name; e.v = {p.ctrl, p.st, exp_cnt, p.err};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.v);
            end
            if (p.rst && !p.ctrl[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout_saturate();
        stim_t s;
        stim_t w;
        step_t p;
        exp_t  e;
        add("to_reset", idle(), 1'b0, OFF, HZ_RUN, 1'b0);
        w = idle(); w.req = 1;
        add("to_enter", w, 1'b1, MSTALL, HZ_RUN, 1'b0);
        add("to_mw1", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        add("to_mw2", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        add("to_mw3", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        add("to_mw4", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        add("to_err_set", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b1);
        w.rdy = 1;
        add("to_ready", w, 1'b1, NORM, HZ_MEMWAIT, 1'b1);
        add("to_sticky", idle(), 1'b1, NORM, HZ_RUN, 1'b1);
        s = idle(); s.rs1 = 3; s.use1 = 1; s.exr = 3; s.exm = 1;
        add("sat_a", s, 1'b1, DSTALL, HZ_RUN, 1'b1);
        add("sat_b", s, 1'b1, DSTALL, HZ_RUN, 1'b1);
        add("sat_c", s, 1'b1, DSTALL, HZ_RUN, 1'b1);
        add("sat_hold", idle(), 1'b1, NORM, HZ_RUN, 1'b1);
        add("to_clear", idle(), 1'b0, OFF, HZ_RUN, 1'b0);
        while (plan.size() != 0) begin
            p = plan.pop_front();
            drive(p.s);
            rst_n = p.rst;
            if (!p.rst) exp_cnt = '0;
            e.name = p.name; e.v = {p.ctrl, p.st, exp_cnt, p.err};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.v);
            end
            if (p.rst && !p.ctrl[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundary();
        stim_t s;
        stim_t w;
        step_t p;
        exp_t  e;
        s = idle(); s.use1 = 1; s.exm = 1;
        add("x0_load", s, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.use1 = 1; s.exw = 1;
        add("x0_br_ex", s, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.use2 = 1; s.mm = 1;
        add("x0_br_mem", s, 1'b1, NORM, HZ_RUN, 1'b0);
        s = idle(); s.rs1 = 5; s.use1 = 1; s.exr = 5; s.exm = 1; s.taken = 1;
        add("lu_blocks_redir", s, 1'b1, DSTALL, HZ_RUN, 1'b0);
        s = idle(); s.is_br = 1; s.rs1 = 3; s.use1 = 1; s.exr = 3; s.exw = 1; s.taken = 1;
        add("brhz_blocks_redir", s, 1'b1, DSTALL, HZ_RUN, 1'b0);
        w = idle(); w.req = 1;
        add("rw_enter", w, 1'b1, MSTALL, HZ_RUN, 1'b0);
        add("rw_wait", w, 1'b1, MSTALL, HZ_MEMWAIT, 1'b0);
        add("rw_reset", w, 1'b0, OFF, HZ_RUN, 1'b0);
        add("rw_released", idle(), 1'b1, NORM, HZ_RUN, 1'b0);
        add("rw_reenter", w, 1'b1, MSTALL, HZ_RUN, 1'b0);
        w.rdy = 1;
        add("rw_done", w, 1'b1, NORM, HZ_MEMWAIT, 1'b0);
        add("rw_tail", idle(), 1'b1, NORM, HZ_RUN, 1'b0);
        while (plan.size() != 0) begin
            p = plan.pop_front();
            drive(p.s);
            rst_n = p.rst;
            if (!p.rst) exp_cnt = '0;
            e.name = p.name; e.v = {p.ctrl, p.st, exp_cnt, p.err};
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.v);
            end
            if (p.rst && !p.ctrl[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        exp_cnt = '0;
        drive(idle());
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_timeout_saturate();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
